// File: rtl/shift_rows_pipe_pkg.sv
// Shared Rijndael ShiftRows helpers: row offsets, byte/column indexing and the
// state permutation itself, sized for the widest (NB=8) block.
package aes_pkg;

    localparam int NB_MAX = 8;
    localparam int DW_MAX = 32 * NB_MAX;

    // Rijndael uses offsets {0,1,2,3} up to NB=6 and {0,1,3,4} for NB=8.
    function automatic int row_offset(input int nb, input int r);
        return (nb == 8 && r >= 2) ? r + 1 : r;
    endfunction

    function automatic int byte_idx(input int c, input int r);
        return 4 * c + r;
    endfunction

    function automatic int src_col(input int nb, input int c, input int r, input bit inv);
        int off;
        off = row_offset(nb, r);
        return inv ? (c - off + nb) % nb : (c + off) % nb;
    endfunction

    function automatic logic [DW_MAX-1:0] shift_rows(input logic [DW_MAX-1:0] state,
                                                     input int nb,
                                                     input logic inv);
        logic [DW_MAX-1:0] res;
        logic [7:0]        enc_b;
        logic [7:0]        dec_b;
        res = '0;
        for (int c = 0; c < NB_MAX; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (c < nb) begin
                    enc_b = state[8*byte_idx(src_col(nb, c, r, 1'b0), r) +: 8];
                    dec_b = state[8*byte_idx(src_col(nb, c, r, 1'b1), r) +: 8];
                    res[8*byte_idx(c, r) +: 8] = inv ? dec_b : enc_b;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/shift_rows_pipe_if.sv
// Valid/ready beat carrying a Rijndael state, its direction flag and a sideband tag.
interface shift_rows_pipe_if #(
    parameter int DW   = 128,
    parameter int TAGW = 4
);
    logic            valid;
    logic            ready;
    logic [DW-1:0]   data;
    logic            inv;
    logic [TAGW-1:0] tag;

    modport master (output valid, data, inv, tag, input ready);
    modport slave  (input valid, data, inv, tag, output ready);
endinterface

// File: rtl/shift_rows_pipe_rs_stage.sv
// One valid/ready register slice holding data, tag and a valid bit; loads when
// empty or when its current contents leave in the same cycle.
module rs_stage #(
    parameter int DW   = 128,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            up_valid,
    output logic            up_ready,
    input  logic [DW-1:0]   up_data,
    input  logic [TAGW-1:0] up_tag,
    output logic            dn_valid,
    input  logic            dn_ready,
    output logic [DW-1:0]   dn_data,
    output logic [TAGW-1:0] dn_tag
);

    logic            valid_q, valid_d;
    logic [DW-1:0]   data_q, data_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic            load;

    always_comb begin
        up_ready = !flush && (!valid_q || dn_ready);
        load     = up_valid && up_ready;
        valid_d  = valid_q && !dn_ready;
        if (load) begin
            valid_d = 1'b1;
        end
        // Flush drops whatever is held; a downstream take in this cycle still happened.
        if (flush) begin
            valid_d = 1'b0;
        end
        data_d = load ? up_data : data_q;
        tag_d  = load ? up_tag  : tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign dn_valid = valid_q;
    assign dn_data  = data_q;
    assign dn_tag   = tag_q;

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows/InvShiftRows stage: permutation on the input side,
// followed by a chain of STAGES valid/ready register slices.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    parameter int TAGW   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    shift_rows_pipe_if.slave   in_if,
    shift_rows_pipe_if.master  out_if
);

    localparam int DW = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (!(STAGES == 1 || STAGES == 2)) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be 1 or 2");
    end

    logic [DW_MAX-1:0] state_full;
    logic [DW_MAX-1:0] shifted_full;
    logic [DW-1:0]     perm_data;

    always_comb begin
        state_full         = '0;
        state_full[DW-1:0] = in_if.data;
    end

    assign shifted_full = shift_rows(state_full, NB, in_if.inv);
    assign perm_data    = shifted_full[DW-1:0];

    // Columns beyond NB are always zero after the permutation.
    if (DW < DW_MAX) begin : g_pad
        logic unused_hi;
        assign unused_hi = ^shifted_full[DW_MAX-1:DW];
    end

    logic            vld [STAGES+1];
    logic            rdy [STAGES+1];
    logic [DW-1:0]   dat [STAGES+1];
    logic [TAGW-1:0] tg  [STAGES+1];

    assign vld[0]      = in_if.valid;
    assign dat[0]      = perm_data;
    assign tg[0]       = in_if.tag;
    assign rdy[STAGES] = out_if.ready;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        rs_stage #(
            .DW   (DW),
            .TAGW (TAGW)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_valid (vld[s]),
            .up_ready (rdy[s]),
            .up_data  (dat[s]),
            .up_tag   (tg[s]),
            .dn_valid (vld[s+1]),
            .dn_ready (rdy[s+1]),
            .dn_data  (dat[s+1]),
            .dn_tag   (tg[s+1])
        );
    end

    // Held low throughout reset, not just until the first edge.
    assign in_if.ready  = rst_n && rdy[0];
    assign out_if.valid = vld[STAGES];
    assign out_if.data  = dat[STAGES];
    assign out_if.tag   = tg[STAGES];
    assign out_if.inv   = 1'b0;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe across NB=4/8/6 and STAGES=1/2 instances.
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    int           sel = 0;
    logic         a_valid = 1'b0;
    logic         a_oready = 1'b1;
    logic         rand_ready = 1'b0;
    logic [255:0] drv_data = '0;
    logic         drv_inv = 1'b0;
    logic [3:0]   drv_tag = '0;

    shift_rows_pipe_if #(.DW(128), .TAGW(4)) i4_in  ();
    shift_rows_pipe_if #(.DW(128), .TAGW(4)) i4_out ();
    shift_rows_pipe_if #(.DW(256), .TAGW(4)) i8_in  ();
    shift_rows_pipe_if #(.DW(256), .TAGW(4)) i8_out ();
    shift_rows_pipe_if #(.DW(192), .TAGW(4)) i6_in  ();
    shift_rows_pipe_if #(.DW(192), .TAGW(4)) i6_out ();

    assign i4_in.valid  = a_valid && sel == 0;
    assign i4_in.data   = drv_data[127:0];
    assign i4_in.inv    = drv_inv;
    assign i4_in.tag    = drv_tag;
    assign i4_out.ready = (sel == 0) ? a_oready : 1'b1;
    assign i8_in.valid  = a_valid && sel == 1;
    assign i8_in.data   = drv_data;
    assign i8_in.inv    = drv_inv;
    assign i8_in.tag    = drv_tag;
    assign i8_out.ready = (sel == 1) ? a_oready : 1'b1;
    assign i6_in.valid  = a_valid && sel == 2;
    assign i6_in.data   = drv_data[191:0];
    assign i6_in.inv    = drv_inv;
    assign i6_in.tag    = drv_tag;
    assign i6_out.ready = (sel == 2) ? a_oready : 1'b1;

    shift_rows_pipe #(.NB(4), .STAGES(2), .TAGW(4)) u4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_if(i4_in), .out_if(i4_out));
    shift_rows_pipe #(.NB(8), .STAGES(1), .TAGW(4)) u8 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_if(i8_in), .out_if(i8_out));
    shift_rows_pipe #(.NB(6), .STAGES(2), .TAGW(4)) u6 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_if(i6_in), .out_if(i6_out));

    logic         o_valid;
    logic [255:0] o_data;
    logic [3:0]   o_tag;
    logic         i_ready;

    always_comb begin
        case (sel)
            1: begin
                o_valid = i8_out.valid; o_data = 256'(i8_out.data);
                o_tag = i8_out.tag; i_ready = i8_in.ready;
            end
            2: begin
                o_valid = i6_out.valid; o_data = 256'(i6_out.data);
                o_tag = i6_out.tag; i_ready = i6_in.ready;
            end
            default: begin
                o_valid = i4_out.valid; o_data = 256'(i4_out.data);
                o_tag = i4_out.tag; i_ready = i4_in.ready;
            end
        endcase
    end

    typedef struct {
        logic [255:0] data;
        logic [3:0]   tag;
    } exp_t;

    exp_t         exp_q[$];
    logic [255:0] out_log[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           n_out = 0;
    logic         stalled_prev = 1'b0;
    logic [255:0] held_data = '0;
    logic [3:0]   held_tag = '0;
    logic         last_valid = 1'b0;
    logic         last_in_xfer = 1'b0;

    // Row-rotation reference model, independent of the package helpers.
    function automatic logic [255:0] model(input logic [255:0] s, input int nb, input logic inv);
        logic [7:0]   row [8];
        logic [7:0]   t;
        logic [255:0] res;
        int           off;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            off = (nb == 8 && r >= 2) ? r + 1 : r;
            for (int c = 0; c < nb; c++) row[c] = s[8*(4*c+r) +: 8];
            for (int k = 0; k < off; k++) begin
                if (!inv) begin
                    t = row[0];
                    for (int c = 0; c < nb - 1; c++) row[c] = row[c+1];
                    row[nb-1] = t;
                end else begin
                    t = row[nb-1];
                    for (int c = nb - 1; c > 0; c--) row[c] = row[c-1];
                    row[0] = t;
                end
            end
            for (int c = 0; c < nb; c++) res[8*(4*c+r) +: 8] = row[c];
        end
        return res;
    endfunction

    function automatic int nb_of(input int s);
        return (s == 1) ? 8 : (s == 2) ? 6 : 4;
    endfunction

    function automatic logic [255:0] rand_state(input int nb);
        logic [255:0] x;
        logic [255:0] mask;
        for (int i = 0; i < 8; i++) x[32*i +: 32] = $urandom;
        mask = (256'd1 << (nb * 32)) - 256'd1;
        return x & mask;
    endfunction

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic fail(input string name, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        n_errors++;
        $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    // One clock: called at a falling edge with inputs set, samples 2 units later.
    task automatic tick();
        exp_t e;
        if (rand_ready) a_oready = 1'($urandom_range(0, 1));
        #2;
        if (stalled_prev) begin
            check("stall_valid", 256'(o_valid), 256'(1'b1));
            check("stall_data", o_data, held_data);
            check("stall_tag", 256'(o_tag), 256'(held_tag));
        end
        last_valid   = o_valid;
        last_in_xfer = a_valid && i_ready;
        if (o_valid && a_oready) begin
            out_log.push_back(o_data);
            n_out++;
            if (exp_q.size() == 0) begin
                fail("unexpected_out", o_data, '0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", o_data, e.data);
                check("out_tag", 256'(o_tag), 256'(e.tag));
            end
        end
        stalled_prev = o_valid && !a_oready && !flush;
        held_data    = o_data;
        held_tag     = o_tag;
        if (last_in_xfer) begin
            e.data = model(drv_data, nb_of(sel), drv_inv);
            e.tag  = drv_tag;
            exp_q.push_back(e);
        end
        if (flush) exp_q.delete();
        @(negedge clk);
    endtask

    task automatic send(input logic [255:0] d, input logic inv, input logic [3:0] t);
        int n;
        drv_data = d; drv_inv = inv; drv_tag = t;
        a_valid = 1'b1;
        last_in_xfer = 1'b0;
        n = 0;
        while (!last_in_xfer && n < 100) begin
            tick();
            n++;
        end
        if (!last_in_xfer) fail("send_timeout", 256'(n), 256'(0));
        a_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        a_valid = 1'b0;
        while (exp_q.size() > 0 && n < 2000) begin
            tick();
            n++;
        end
        check("drain_empty", 256'(exp_q.size()), 256'(0));
    endtask

    task automatic roundtrip(input int n);
        logic [255:0] orig[$];
        logic [255:0] enc[$];
        logic [255:0] x;
        int           nb;
        nb = nb_of(sel);
        out_log.delete();
        for (int i = 0; i < n; i++) begin
            x = rand_state(nb);
            orig.push_back(x);
            send(x, 1'b0, 4'(i));
        end
        drain();
        enc = out_log;
        out_log.delete();
        for (int i = 0; i < enc.size(); i++) send(enc[i], 1'b1, 4'(i));
        drain();
        check("rt_count", 256'(out_log.size()), 256'(n));
        for (int i = 0; i < n && i < out_log.size(); i++) check("rt_data", out_log[i], orig[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d;
        int           n0;
        int           n;

        // Reset state
        #1;
        check("rst_out_valid", 256'(i4_out.valid), 256'(1'b0));
        check("rst_out_data", 256'(i4_out.data), 256'(0));
        check("rst_out_tag", 256'(i4_out.tag), 256'(0));
        check("rst_in_ready", 256'(i4_in.ready), 256'(1'b0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("post_rst_in_ready", 256'(i_ready), 256'(1'b1));
        @(negedge clk);

        // NB=4 known vectors
        sel = 0;
        d = 256'(128'h0F0E0D0C0B0A09080706050403020100);
        send(d, 1'b0, 4'd1);
        drain();
        check("nb4_enc_const", out_log[$], 256'(128'h0B06010C07020D08030E09040F0A0500));
        send(256'(128'h0B06010C07020D08030E09040F0A0500), 1'b1, 4'd2);
        drain();
        check("nb4_dec_const", out_log[$], d);

        // NB=8 column 0 after encrypt
        sel = 1;
        for (int k = 0; k < 32; k++) d[8*k +: 8] = 8'(k);
        send(d, 1'b0, 4'd3);
        drain();
        check("nb8_col0", 256'(out_log[$][31:0]), 256'(32'h130E0500));

        // Round trips through the hardware
        roundtrip(1000);
        sel = 2;
        roundtrip(1000);

        // STAGES=2 stream with random backpressure
        sel = 0;
        rand_ready = 1'b1;
        n0 = n_out;
        for (int i = 1; i <= 8; i++) send(rand_state(4), 1'($urandom_range(0, 1)), 4'(i));
        drain();
        rand_ready = 1'b0;
        a_oready = 1'b1;
        check("stream_count", 256'(n_out - n0), 256'(8));

        // Two beats fill the STAGES=2 pipe
        a_oready = 1'b0;
        send(rand_state(4), 1'b0, 4'd9);
        send(rand_state(4), 1'b1, 4'd10);
        #2;
        check("full_in_ready", 256'(i_ready), 256'(1'b0));
        @(negedge clk);
        a_oready = 1'b1;
        drain();

        // Flush with two beats in flight and a beat offered at the same time
        a_oready = 1'b0;
        send(rand_state(4), 1'b0, 4'd11);
        send(rand_state(4), 1'b0, 4'd12);
        drv_data = rand_state(4);
        drv_tag = 4'd13;
        a_valid = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_in_ready", 256'(i_ready), 256'(1'b0));
        tick();
        a_valid = 1'b0;
        flush = 1'b0;
        #1;
        check("flush_out_valid", 256'(o_valid), 256'(1'b0));
        tick();
        a_oready = 1'b1;
        n0 = n_out;
        repeat (6) tick();
        check("flush_no_out", 256'(n_out - n0), 256'(0));

        // Asynchronous reset mid-stream
        send(rand_state(4), 1'b0, 4'd1);
        send(rand_state(4), 1'b1, 4'd2);
        send(rand_state(4), 1'b0, 4'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 256'(o_valid), 256'(1'b0));
        check("arst_out_data", o_data, 256'(0));
        check("arst_out_tag", 256'(o_tag), 256'(0));
        check("arst_in_ready", 256'(i_ready), 256'(1'b0));
        exp_q.delete();
        stalled_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(rand_state(4), 1'b0, 4'd14);
        n = 0;
        last_valid = 1'b0;
        while (!last_valid && n < 20) begin
            tick();
            n++;
        end
        check("rst_latency", 256'(n), 256'(2));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
